bp_sndcmd_tx: RTL and testbench
===============================

BP_SNDCMD_TX -- requirements
Module: bp_sndcmd_tx

Interface
REQ-001 Parameter: DEPTH, 4, command queue depth in entries (power of two, 2..16).
REQ-002 Parameter: HOLDOFF, 64, minimum gap between strobes, counted in cen_1m25 ticks (1..255).
REQ-003 Port: clk_49m  in  1  master clock, 49.152 MHz; only clock.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: cen_1m25  in  1  sound-CPU clock enable, one clk_49m cycle wide.
REQ-006 Port: cpu_A  in  16  main-CPU address bus.
REQ-007 Port: cpu_Dout  in  8  main-CPU write data.
REQ-008 Port: n_mreq, n_rd, n_wr, n_rfsh  in  1 each  main-CPU strobes, active-low.
REQ-009 Port: dipsw_readback  in  8  value latched by the sound board.
REQ-010 Port: cpu_Din  out  8  read data for the main-CPU data mux.
REQ-011 Port: dip_oe  out  1  high while the read decode is active.
REQ-012 Port: sound_cmd  out  8  command byte to the sound board.
REQ-013 Port: sound_cmd_wr  out  1  command strobe to the sound board.
REQ-014 Port: overflow  out  1  sticky flag: a command was dropped.

Function
REQ-015 Write decode: ~n_mreq & n_rfsh & ~n_wr & cpu_A[15:12]==4'hD is true; all mirrors within 0xD000-0xDFFF are accepted.
REQ-016 Push: one push per bus write, on the rising edge of the write decode, capturing cpu_Dout sampled in that cycle.
REQ-017 A decode held high for many clk_49m cycles produces exactly one push.
REQ-018 Read decode: ~n_mreq & n_rfsh & ~n_rd & cpu_A[15:12]==4'hC & cpu_A[1:0]==2'b11.
REQ-019 dip_oe equals the read decode combinationally; cpu_Din is dipsw_readback while dip_oe is high, otherwise 8'hFF.
REQ-020 Queue: FIFO of DEPTH x 8 bits; occupancy counter is DEPTH+1 wide; pointers wrap modulo DEPTH.
REQ-021 Push when full (no pop in the same cycle): the byte is dropped, the queue is unchanged, and overflow is set to 1.
REQ-022 Push and pop in the same cycle when full: both take effect; occupancy stays DEPTH; overflow is not set.
REQ-023 Push when empty: the entry becomes poppable on the next cycle; there is no same-cycle bypass.
REQ-024 FSM states IDLE, LOAD, STROBE, HOLD.
REQ-025 IDLE: when the queue is not empty, pop the head into sound_cmd and go to LOAD.
REQ-026 LOAD: sound_cmd_wr stays 0 for this cycle, giving one cycle of setup; go to STROBE.
REQ-027 STROBE: sound_cmd_wr is 1 for exactly one clk_49m cycle; load the holdoff counter with HOLDOFF; go to HOLD.
REQ-028 HOLD: decrement the counter on each cen_1m25; when the counter reaches 0, go to IDLE.
REQ-029 Latency: first strobe is 3 clk_49m cycles after the push cycle (empty queue, IDLE): IDLE pop at +1, LOAD at +2, STROBE at +3.
REQ-030 sound_cmd holds its value from the pop until the next pop; it never changes in LOAD, STROBE or HOLD.
REQ-031 cen_1m25 coincident with STROBE does not decrement the counter; decrementing starts in HOLD.
REQ-032 Pushes are accepted in every FSM state.

Reset
REQ-033 Reset applies asynchronously and is released synchronously to clk_49m.
REQ-034 Reset values: FSM=IDLE, queue empty, pointers=0, counter=0, sound_cmd=8'h00, sound_cmd_wr=0, overflow=0.
REQ-035 Reset asserted mid-STROBE forces sound_cmd_wr low immediately.
REQ-036 Reset discards all queued commands, and the write edge detector resets to 0.
REQ-037 A decode already high when reset is released produces no push.

Structure
REQ-038 Shared package bp_snd_pkg holds the FSM state enum, decode constants (SNDCMD_ADDR_HI=4'hD, DIPRB_ADDR_HI=4'hC, DIPRB_ADDR_LO=2'b11) and the default DEPTH/HOLDOFF.
REQ-039 The queue is one sub-module, bp_sndcmd_fifo (synchronous FIFO with push, pop, full, empty, occupancy).
REQ-040 Decode, edge detection and the FSM live in the top module.

Verification
REQ-041 Scenario: single write of 8'h5A to 0xD000 with the strobe held 20 cycles -> sound_cmd=8'h5A from pop onward; one sound_cmd_wr pulse 3 cycles after the push; no second pulse.
REQ-042 Scenario: writes 8'h01, 8'h02, 8'h03 back-to-back -> three strobes in order; each strobe separated by at least HOLDOFF=64 cen_1m25 ticks.
REQ-043 Scenario: DEPTH=4, six writes during HOLD -> four queued, two dropped, overflow=1; the four bytes are emitted in order.
REQ-044 Scenario: push coincident with pop while full -> no drop; overflow stays 0; order is preserved.
REQ-045 Scenario: read 0xC003 with dipsw_readback=8'hA3 -> cpu_Din=8'hA3 and dip_oe=1; read 0xC002 -> cpu_Din=8'hFF and dip_oe=0.
REQ-046 Scenario: reset asserted during STROBE with 2 entries queued -> sound_cmd_wr=0 at once; after release no strobe occurs; sound_cmd=8'h00.

Source files
------------

// File: rtl/bp_snd_pkg.sv
// Shared definitions for the sound-command transmitter: FSM states,
// bus decode constants and default queue/holdoff sizing.
package bp_snd_pkg;

   localparam int SNDCMD_DEPTH   = 4;
   localparam int SNDCMD_HOLDOFF = 64;

   localparam logic [3:0] SNDCMD_ADDR_HI = 4'hD;
   localparam logic [3:0] DIPRB_ADDR_HI  = 4'hC;
   localparam logic [1:0] DIPRB_ADDR_LO  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STROBE,
      ST_HOLD
   } snd_state_e;

endpackage

// File: rtl/bp_sndcmd_fifo.sv
// Synchronous DEPTH x 8 command queue. A push while full is accepted only
// when a pop frees a slot in the same cycle; dout shows the head entry.
module bp_sndcmd_fifo #(
   parameter int DEPTH = 4
)(
   input  logic             clk_49m,
   input  logic             reset,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic             full,
   output logic             empty,
   output logic [DEPTH:0]   count
);
   localparam int             PW       = $clog2(DEPTH);
   localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_49m) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bp_sndcmd_tx.sv
// Main-CPU to sound-board command path: decodes writes to 0xDxxx into a
// queue, then paces them out as LOAD/STROBE/HOLD sequences. Also returns
// the sound board's DIP readback on reads of 0xCxx3.
module bp_sndcmd_tx
   import bp_snd_pkg::*;
#(
   parameter int DEPTH   = SNDCMD_DEPTH,
   parameter int HOLDOFF = SNDCMD_HOLDOFF
)(
   input  logic        clk_49m,
   input  logic        reset,
   input  logic        cen_1m25,
   input  logic [15:0] cpu_A,
   input  logic [7:0]  cpu_Dout,
   input  logic        n_mreq,
   input  logic        n_rd,
   input  logic        n_wr,
   input  logic        n_rfsh,
   input  logic [7:0]  dipsw_readback,
   output logic [7:0]  cpu_Din,
   output logic        dip_oe,
   output logic [7:0]  sound_cmd,
   output logic        sound_cmd_wr,
   output logic        overflow
);
   localparam logic [7:0] HOLD_LD = 8'(HOLDOFF);

   snd_state_e     state;
   snd_state_e     state_n;
   logic [7:0]     hold_cnt;
   logic           wr_dec;
   logic           rd_dec;
   logic           wr_dec_q;
   logic           armed;
   logic           wr_push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [7:0]     fifo_dout;
   logic [DEPTH:0] occ_unused;
   logic           unused_addr;

   assign unused_addr = ^cpu_A[11:2];

   assign wr_dec = ~n_mreq & n_rfsh & ~n_wr & (cpu_A[15:12] == SNDCMD_ADDR_HI);
   assign rd_dec = ~n_mreq & n_rfsh & ~n_rd & (cpu_A[15:12] == DIPRB_ADDR_HI)
                 & (cpu_A[1:0] == DIPRB_ADDR_LO);

   assign dip_oe  = rd_dec;
   assign cpu_Din = rd_dec ? dipsw_readback : 8'hFF;

   // armed stays low for the first cycle after reset so a decode that is
   // already high at release is seen as "previously high" and never pushes.
   assign wr_push = wr_dec & ~wr_dec_q & armed;

   // Write-decode edge detector.
   always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
         wr_dec_q <= 1'b0;
         armed    <= 1'b0;
      end else begin
         wr_dec_q <= wr_dec;
         armed    <= 1'b1;
      end
   end

   bp_sndcmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_49m (clk_49m),
      .reset   (reset),
      .push    (wr_push),
      .din     (cpu_Dout),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (occ_unused)
   );

   // Sticky drop flag: only a push that finds no free slot sets it.
   always_ff @(posedge clk_49m or posedge reset) begin
      if (reset)                             overflow <= 1'b0;
      else if (wr_push & fifo_full & ~pop)   overflow <= 1'b1;
   end

   // State, holdoff counter and the command byte latched at pop time.
   always_ff @(posedge clk_49m or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         sound_cmd <= '0;
      end else begin
         state <= state_n;
         if (pop) sound_cmd <= fifo_dout;
         if (state == ST_STROBE)
            hold_cnt <= HOLD_LD;
         else if (state == ST_HOLD && cen_1m25 && hold_cnt != '0)
            hold_cnt <= hold_cnt - 1'b1;
      end
   end

   // Next-state and strobe; HOLD exits on the tick that takes the count to 0.
   always_comb begin
      state_n      = state;
      pop          = 1'b0;
      sound_cmd_wr = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_n = ST_LOAD;
            end
         end
         ST_LOAD:   state_n = ST_STROBE;
         ST_STROBE: begin
            sound_cmd_wr = 1'b1;
            state_n      = ST_HOLD;
         end
         ST_HOLD: begin
            if (hold_cnt == '0 || (cen_1m25 && hold_cnt == 8'd1))
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bp_sndcmd_tx.sv
// Directed bench for bp_sndcmd_tx: one task per scenario, inline checks.
module tb_bp_sndcmd_tx;
   localparam int HOLD = 64;
   localparam int CDIV = 8;

   logic        clk_49m = 1'b0;
   logic        reset = 1'b1;
   logic        cen_1m25 = 1'b0;
   logic [15:0] cpu_A = '0;
   logic [7:0]  cpu_Dout = '0;
   logic        n_mreq = 1'b1, n_rd = 1'b1, n_wr = 1'b1, n_rfsh = 1'b1;
   logic [7:0]  dipsw_readback = '0;
   logic [7:0]  cpu_Din;
   logic        dip_oe;
   logic [7:0]  sound_cmd;
   logic        sound_cmd_wr;
   logic        overflow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int cen_div = 0;
   int cen_cnt = 0;
   logic [7:0] sb_byte[$];
   int         sb_cyc[$];
   int         sb_cen[$];

   bp_sndcmd_tx #(.DEPTH(4), .HOLDOFF(HOLD)) dut (
      .clk_49m(clk_49m), .reset(reset), .cen_1m25(cen_1m25),
      .cpu_A(cpu_A), .cpu_Dout(cpu_Dout), .n_mreq(n_mreq), .n_rd(n_rd),
      .n_wr(n_wr), .n_rfsh(n_rfsh), .dipsw_readback(dipsw_readback),
      .cpu_Din(cpu_Din), .dip_oe(dip_oe), .sound_cmd(sound_cmd),
      .sound_cmd_wr(sound_cmd_wr), .overflow(overflow)
   );

   always #5 clk_49m = ~clk_49m;

   // cycle counter and clock-enable generator (one cycle in CDIV)
   initial forever begin
      @(posedge clk_49m);
      cyc++;
      #1;
      cen_div  = (cen_div + 1) % CDIV;
      cen_1m25 = (cen_div == 0);
   end

   // strobe monitor: log byte, cycle and cumulative cen count of every strobe
   initial forever begin
      @(negedge clk_49m);
      if (cen_1m25) cen_cnt++;
      if (sound_cmd_wr === 1'b1) begin
         sb_byte.push_back(sound_cmd);
         sb_cyc.push_back(cyc);
         sb_cen.push_back(cen_cnt);
      end
   end

   task automatic clear_log();
      sb_byte.delete(); sb_cyc.delete(); sb_cen.delete();
   endtask

   task automatic bus_idle();
      n_mreq = 1'b1; n_wr = 1'b1; n_rd = 1'b1; n_rfsh = 1'b1; cpu_A = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus_idle();
      repeat (3) @(posedge clk_49m);
      #1 reset = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_49m);
      #1;
   endtask

   // one bus write; pcyc is the first cycle the write decode is high
   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, input int lo,
                         output int pcyc);
      @(posedge clk_49m); #1;
      cpu_A = a; cpu_Dout = d; n_mreq = 1'b0; n_wr = 1'b0;
      pcyc = cyc;
      repeat (lo) @(posedge clk_49m);
      #1 bus_idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_A = 16'hD123; cpu_Dout = 8'h77; n_mreq = 1'b0; n_wr = 1'b0;
      wait_cyc(3);
      checks++; if (sound_cmd !== 8'h00) begin errors++; $display("FAIL rst_cmd: got %h want 00", sound_cmd); end
      checks++; if (sound_cmd_wr !== 1'b0) begin errors++; $display("FAIL rst_wr: got %b want 0", sound_cmd_wr); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      checks++; if (cpu_Din !== 8'hFF || dip_oe !== 1'b0) begin errors++; $display("FAIL rst_din: got %h/%b want FF/0", cpu_Din, dip_oe); end
      clear_log();
      reset = 1'b0;            // released with the write decode already high
      wait_cyc(10);
      bus_idle();
      wait_cyc(20);
      checks++; if (sb_byte.size() != 0) begin errors++; $display("FAIL rst_held_decode: got %0d strobes want 0", sb_byte.size()); end
      checks++; if (sound_cmd !== 8'h00) begin errors++; $display("FAIL rst_held_cmd: got %h want 00", sound_cmd); end
   endtask

   task automatic test_single();
      int p;
      apply_reset(); clear_log();
      cpu_wr(16'hD000, 8'h5A, 20, p);
      wait_cyc(HOLD*CDIV + 40);
      checks++; if (sb_byte.size() != 1) begin errors++; $display("FAIL single_count: got %0d want 1", sb_byte.size()); end
      if (sb_byte.size() >= 1) begin
         checks++; if (sb_byte[0] !== 8'h5A) begin errors++; $display("FAIL single_byte: got %h want 5A", sb_byte[0]); end
         checks++; if (sb_cyc[0] - p != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", sb_cyc[0] - p); end
      end
      checks++; if (sound_cmd !== 8'h5A) begin errors++; $display("FAIL single_hold: got %h want 5A", sound_cmd); end
   endtask

   task automatic test_back_to_back();
      int p;
      clear_log();
      for (int i = 1; i <= 3; i++) cpu_wr(16'hD000, 8'(i), 2, p);
      wait_cyc(3*(HOLD*CDIV + 16) + 50);
      checks++; if (sb_byte.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", sb_byte.size()); end
      for (int i = 0; i < 3 && i < sb_byte.size(); i++) begin
         checks++; if (sb_byte[i] !== 8'(i+1)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, sb_byte[i], 8'(i+1)); end
      end
      for (int i = 1; i < sb_cen.size(); i++) begin
         checks++; if (sb_cen[i] - sb_cen[i-1] < HOLD) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d ticks want >= %0d", i, sb_cen[i]-sb_cen[i-1], HOLD); end
      end
   endtask

   task automatic test_overflow();
      int p;
      logic [7:0] exp [5];
      exp = '{8'hAA, 8'h10, 8'h11, 8'h12, 8'h13};
      apply_reset(); clear_log();
      cpu_wr(16'hD000, 8'hAA, 2, p);
      wait_cyc(10);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b want 0", overflow); end
      for (int i = 0; i < 6; i++) cpu_wr(16'hD000 + 16'(i*16'h111), 8'h10 + 8'(i), 2, p);
      wait_cyc(1);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      wait_cyc(5*(HOLD*CDIV + 16) + 50);
      checks++; if (sb_byte.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d want 5", sb_byte.size()); end
      for (int i = 0; i < 5 && i < sb_byte.size(); i++) begin
         checks++; if (sb_byte[i] !== exp[i]) begin errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, sb_byte[i], exp[i]); end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_full_pop();
      int p;
      int target;
      int n;
      apply_reset(); clear_log();
      cpu_wr(16'hD000, 8'hB0, 2, p);
      wait_cyc(5);
      checks++; if (sb_byte.size() != 1) begin errors++; $display("FAIL fp_first: got %0d strobes want 1", sb_byte.size()); end
      for (int i = 1; i <= 4; i++) cpu_wr(16'hD800, 8'hB0 + 8'(i), 2, p);
      if (sb_cen.size() >= 1) begin
         // the 64th tick after the strobe ends HOLD; the next cycle pops while full
         target = sb_cen[0] + HOLD;
         n = 0;
         while (cen_cnt < target && n < 2000) begin
            @(negedge clk_49m); #1; n++;
         end
         checks++; if (cen_cnt < target) begin errors++; $display("FAIL fp_timeout: got %0d ticks want %0d", cen_cnt, target); end
         cpu_wr(16'hDFFF, 8'hB5, 2, p);
      end
      wait_cyc(6*(HOLD*CDIV + 16));
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b want 0", overflow); end
      checks++; if (sb_byte.size() != 6) begin errors++; $display("FAIL fp_count: got %0d want 6", sb_byte.size()); end
      for (int i = 0; i < 6 && i < sb_byte.size(); i++) begin
         checks++; if (sb_byte[i] !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL fp_order[%0d]: got %h want %h", i, sb_byte[i], 8'hB0 + 8'(i)); end
      end
   endtask

   task automatic test_dip_read();
      dipsw_readback = 8'hA3;
      cpu_A = 16'hC003; n_mreq = 1'b0; n_rd = 1'b0;
      #1;
      checks++; if (cpu_Din !== 8'hA3 || dip_oe !== 1'b1) begin errors++; $display("FAIL dip_c003: got %h/%b want A3/1", cpu_Din, dip_oe); end
      cpu_A = 16'hC002; #1;
      checks++; if (cpu_Din !== 8'hFF || dip_oe !== 1'b0) begin errors++; $display("FAIL dip_c002: got %h/%b want FF/0", cpu_Din, dip_oe); end
      cpu_A = 16'hCFF3; #1;
      checks++; if (cpu_Din !== 8'hA3 || dip_oe !== 1'b1) begin errors++; $display("FAIL dip_mirror: got %h/%b want A3/1", cpu_Din, dip_oe); end
      n_rfsh = 1'b0; #1;
      checks++; if (cpu_Din !== 8'hFF || dip_oe !== 1'b0) begin errors++; $display("FAIL dip_rfsh: got %h/%b want FF/0", cpu_Din, dip_oe); end
      n_rfsh = 1'b1; cpu_A = 16'hD003; #1;
      checks++; if (cpu_Din !== 8'hFF || dip_oe !== 1'b0) begin errors++; $display("FAIL dip_d003: got %h/%b want FF/0", cpu_Din, dip_oe); end
      bus_idle();
      wait_cyc(2);
   endtask

   task automatic test_reset_strobe();
      int p;
      int n;
      apply_reset(); clear_log();
      cpu_wr(16'hD000, 8'hC0, 2, p);
      wait_cyc(10);
      cpu_wr(16'hD000, 8'hC1, 2, p);
      cpu_wr(16'hD000, 8'hC2, 2, p);
      cpu_wr(16'hD000, 8'hC3, 2, p);
      n = 0;
      do begin
         @(negedge clk_49m); n++;
      end while (sound_cmd_wr !== 1'b1 && n < 2000);
      checks++; if (sound_cmd_wr !== 1'b1 || sound_cmd !== 8'hC1) begin errors++; $display("FAIL rs_strobe: got %b/%h want 1/C1", sound_cmd_wr, sound_cmd); end
      #2 reset = 1'b1;
      #1;
      checks++; if (sound_cmd_wr !== 1'b0) begin errors++; $display("FAIL rs_wr_async: got %b want 0", sound_cmd_wr); end
      checks++; if (sound_cmd !== 8'h00) begin errors++; $display("FAIL rs_cmd_async: got %h want 00", sound_cmd); end
      wait_cyc(3);
      reset = 1'b0;
      clear_log();
      wait_cyc(HOLD*CDIV + 100);
      checks++; if (sb_byte.size() != 0) begin errors++; $display("FAIL rs_no_strobe: got %0d want 0", sb_byte.size()); end
      checks++; if (sound_cmd !== 8'h00) begin errors++; $display("FAIL rs_cmd_after: got %h want 00", sound_cmd); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_dip_read();
      test_reset_strobe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
